// File: rtl/fmul_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fmul_issue_buffer
// Description : Issue front end for a fixed-latency fmul pipeline. Registers
//               operand pairs towards fmul, tracks in-flight ops with a
//               valid/tag shift register and captures results into an output
//               FIFO. Credit-based issue means a stalled consumer never
//               causes a result to be dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_issue_buffer #(
    parameter int LATENCY    = 2,
    parameter int OBUF_DEPTH = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fmul_op1,
    output logic [31:0]      fmul_op2,
    input  logic [31:0]      fmul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Operands change at the issue edge and the product is valid LATENCY
    // edges later, so it is captured one edge after that: LATENCY+1 stages.
    localparam int c_STAGES = LATENCY + 1;
    localparam int c_PTR_W  = $clog2(OBUF_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_SUM_W  = $clog2(OBUF_DEPTH + LATENCY + 2);

    logic [c_STAGES-1:0] r_pipe_v;
    logic [TAG_W-1:0]    r_pipe_tag [c_STAGES];
    logic [31:0]         r_op1;
    logic [31:0]         r_op2;
    logic [31:0]         r_mem_res  [OBUF_DEPTH];
    logic [TAG_W-1:0]    r_mem_tag  [OBUF_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [c_SUM_W-1:0]  w_inflight;
    logic [c_SUM_W-1:0]  w_occupancy;
    logic                w_in_ready;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_out_valid;

    // Count ops in flight inside the fmul pipe (popcount of stage valids)
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < c_STAGES; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_pipe_v[i]);
        end
    end

    // Credit check uses registered state only, so out_ready/in_valid never
    // reach in_ready combinationally; a pop frees its slot one cycle later.
    always_comb begin
        w_occupancy = c_SUM_W'(r_count) + w_inflight;
        w_in_ready  = !reset && (w_occupancy < c_SUM_W'(OBUF_DEPTH));
        w_issue     = in_valid && w_in_ready;
        w_push      = r_pipe_v[c_STAGES-1];
        w_out_valid = (r_count != '0);
        w_pop       = w_out_valid && out_ready;
    end

    // Operand registers towards fmul; hold value when nothing issues
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op1 <= '0;
            r_op2 <= '0;
        end else if (w_issue) begin
            r_op1 <= in_op1;
            r_op2 <= in_op2;
        end
    end

    // In-flight valid shift register; ops in flight at reset are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_v <= '0;
        end else begin
            r_pipe_v <= {r_pipe_v[c_STAGES-2:0], w_issue};
        end
    end

    // Tag shift register travelling alongside the valid bits
    always_ff @(posedge clk) begin
        r_pipe_tag[0] <= in_tag;
        for (int i = 1; i < c_STAGES; i++) begin
            r_pipe_tag[i] <= r_pipe_tag[i-1];
        end
    end

    // FIFO storage: capture product and tag when the oldest stage is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_res[r_wr_ptr] <= fmul_result;
            r_mem_tag[r_wr_ptr] <= r_pipe_tag[c_STAGES-1];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign fmul_op1   = r_op1;
    assign fmul_op2   = r_op2;
    assign out_valid  = w_out_valid;
    assign out_result = r_mem_res[r_rd_ptr];
    assign out_tag    = r_mem_tag[r_rd_ptr];
    assign busy       = (w_inflight != '0) || (r_count != '0);

endmodule
`default_nettype wire
